// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the round-robin arbiter
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational first-set search over 8 requests starting at a rotating index
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] start,
  input  logic [ARB_IDX_W-1:0] mask_idx,
  input  logic                 mask_en,
  output logic                 found,
  output logic [ARB_IDX_W-1:0] idx
);

  logic [ARB_IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = 0; k < ARB_N; k++) begin
      // 3-bit add wraps naturally, giving the mod-8 scan order
      cand = start + k[ARB_IDX_W-1:0];
      if (!found && req[cand] && !(mask_en && (cand == mask_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with hold-limit preemption
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] sel,
  output logic                 valid,
  output logic                 preempt
);

  localparam logic [7:0] HOLD_SAT = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [ARB_N-1:0]     gnt_q, gnt_d;
  logic [ARB_IDX_W-1:0] sel_q, sel_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic                 preempt_q, preempt_d;

  logic                 owner_req;
  logic                 contended;
  logic                 timeout_hit;
  logic [ARB_IDX_W-1:0] pick_start;
  logic                 pick_mask_en;
  logic                 pick_found;
  logic [ARB_IDX_W-1:0] pick_idx;

  assign owner_req   = req[sel_q];
  assign contended   = |(req & ~gnt_q);
  assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT) && owner_req && contended;

  // While granted, search starts after the owner; the owner is masked only when it still requests
  assign pick_start   = (state_q == ST_GRANT) ? sel_q + 3'd1 : ptr_q;
  assign pick_mask_en = (state_q == ST_GRANT) && owner_req;

  rr_pick8 u_pick (
    .req      (req),
    .start    (pick_start),
    .mask_idx (sel_q),
    .mask_en  (pick_mask_en),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          gnt_d      = 8'b1 << pick_idx;
          sel_d      = pick_idx;
          hold_cnt_d = 8'd0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          ptr_d      = sel_q + 3'd1;
          hold_cnt_d = 8'd0;
          if (pick_found) begin
            gnt_d = 8'b1 << pick_idx;
            sel_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (timeout_hit) begin
          ptr_d      = sel_q + 3'd1;
          gnt_d      = 8'b1 << pick_idx;
          sel_d      = pick_idx;
          hold_cnt_d = 8'd0;
          preempt_d  = 1'b1;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= 8'd0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = (state_q == ST_GRANT);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed vector bench for rr_arbiter8 with MAX_HOLD=4
module tb_rr_arbiter8;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       preempt;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       preempt;

  int n_total;
  int n_pass;
  vec_t vecs[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                     input logic v, input logic p);
    vec_t t;
    t.req = r; t.gnt = g; t.sel = s; t.valid = v; t.preempt = p;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es,
                       input logic ev, input logic ep);
    n_total++;
    if (gnt === eg && sel === es && valid === ev && preempt === ep) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gnt=%h sel=%0d valid=%b preempt=%b, expected gnt=%h sel=%0d valid=%b preempt=%b",
               name, gnt, sel, valid, preempt, eg, es, ev, ep);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // reset priority: req held at FF through reset, first grant goes to 0
    add(8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
    // wrap-around from owner 0, ptr 0
    add(8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // contended timeout between 2 and 5
    for (int i = 0; i < 4; i++) add(8'h24, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h24, 8'h20, 3'd5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(8'h24, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h24, 8'h04, 3'd2, 1'b1, 1'b1);
    add(8'h24, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    // solo holder, then a competitor appears after saturation
    for (int i = 0; i < 10; i++) add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h0A, 8'h02, 3'd1, 1'b1, 1'b1);
    add(8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
    // idle return keeps sel at the last owner
    add(8'h40, 8'h40, 3'd6, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd6, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd6, 1'b0, 1'b0);
    // release coinciding with saturation: handover without preempt
    for (int i = 0; i < 4; i++) add(8'h11, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
    add(8'h30, 8'h20, 3'd5, 1'b1, 1'b0);

    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(negedge clk);
    check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].req;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].preempt);
    end

    // asynchronous reset between edges while index 5 is granted
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_grant", 8'h10, 3'd4, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one 8:1-selected resource, such as a shared result bus or write port in the mono-cycle MIPS datapath. It grants exactly one requester at a time. It drives the 3-bit select of the downstream 8:1 selector and a matching one-hot grant vector. Ownership lasts until the owner drops its request or a programmable hold limit expires while others are waiting.

## Interface
Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption when others wait. Range 0..255; 0 = unlimited (no preemption).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; req[i] is held high while requester i wants or holds the resource.
- gnt  output  8  one-hot grant; all zero when idle.
- sel  output  3  binary index of the current or last owner; drives the 8:1 selector condition.
- valid  output  1  high when a grant is active (gnt != 0).
- preempt  output  1  one-cycle pulse on the edge where a grant moved because MAX_HOLD expired.

Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- **Reset values:** gnt=8'h00, sel=3'd0, valid=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE.
- **ptr:** the search start index.
- **Pick function:** returns the first i with req[i]=1, scanning ptr, ptr+1, … ptr+7, with indices taken mod 8.
- **IDLE state:**
  - No request: stay in IDLE with gnt=0 and valid=0; sel holds its last value.
  - Any request: pick a winner w. Next edge: state=GRANT, gnt=1<<w, sel=w, valid=1, hold_cnt=0.
- **GRANT state, owner o:**
  - Each cycle, hold_cnt increments, saturating at MAX_HOLD-1 (or at 255 when MAX_HOLD=0).
- **Release (req[o]=0):**
  - ptr becomes o+1 mod 8 and a pick runs from it.
  - If a winner exists, the grant hands over directly on the next edge with no idle bubble; hold_cnt=0.
  - Otherwise go to IDLE with gnt=0 and valid=0; sel stays at o.
- **Timeout:** applies when MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, req[o]=1, and some req[j]=1 with j≠o.
  - Pick from o+1, so the owner is effectively lowest priority; the winner is never o.
  - Next edge: grant moves to the winner, hold_cnt=0, preempt=1 for that one cycle.
- **Timeout with no competitor:** the owner keeps the grant and hold_cnt stays saturated. Preemption then fires on the first cycle a competitor appears.
- **Grant invariants:** gnt, sel and valid always update on the same edge. gnt is never multi-hot. sel equals the gnt index whenever valid=1.
- **Unrequested owner:** requests from non-owners never affect the current grant except through timeout. An owner is never granted without its req bit set on the deciding cycle.

## Timing
- Latency from request to grant (from IDLE): 1 cycle, meaning req sampled at edge k gives gnt at edge k+1.
- Latency from release to handover: 1 cycle. The owner sees its gnt deasserted or moved one cycle after dropping req, so it must tolerate one extra granted cycle.
- Timeout: the owner holds the grant for exactly MAX_HOLD cycles when contended.
- preempt is registered and is high for exactly one cycle.
- Reset mid-operation: all outputs take their reset values immediately and asynchronously, with no clock needed. The first grant after rst_n deasserts starts its search at index 0.
- Simultaneous owner release and timeout: release takes priority, so preempt=0.

## Structure
- Shared package `arb_pkg`:
  - ARB_N=8
  - ARB_IDX_W=3
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
- Sub-module `rr_pick8`: purely combinational.
  - Inputs: req[7:0], start[2:0], mask_idx[2:0], mask_en.
  - Outputs: found, idx[2:0].
  - Instantiated once and used for idle, release and timeout picks.
- The 8:1 selector itself is instantiated outside this block and driven by sel.

## Test plan
- **Reset priority:** hold req=8'hFF through reset. The first edge after release gives gnt=8'h01, sel=0, valid=1.
- **Wrap-around:** start with req=8'h81 and ptr=0, so gnt=8'h01. Drop req[0]; the next edge gives gnt=8'h80, sel=7. Drop req[7] and raise req[0]; this gives gnt=8'h01, sel=0.
- **Contended timeout (MAX_HOLD=4):** hold req[2] and req[5] continuously. gnt=8'h04 for 4 cycles, then 8'h20 with preempt=1 for one cycle. After 4 more cycles, gnt=8'h04 with preempt=1.
- **Solo holder (MAX_HOLD=4):** hold only req[3] for 10 cycles. gnt=8'h08 throughout and preempt stays 0. Raise req[1]; the next edge gives gnt=8'h02 and preempt=1.
- **Idle return:** grant req[6] only, then drop it. The next edge gives gnt=8'h00, valid=0, and sel stays 6.
- **Async reset mid-grant:** pull rst_n low between clock edges. gnt=0, sel=0, valid=0 and preempt=0 immediately. After release with req=8'h30, the grant goes to index 4.
